// File: rtl/uart_reg_initiator.sv
// uart_reg_initiator: register-bus initiator for the uart_registers slave port.
// After reset it writes BOOT_CONFIG to BOOT_ADDR. It then serves single
// read/write host commands. Each command returns exactly one response, and a
// bounded wait turns a silent responder into an error response.
// Optional feature macro: UART_INIT_READBACK_EN. When it is defined, the boot
// sequence reads the config word back, and boot_ok requires an exact match.
module uart_reg_initiator #(
  parameter int unsigned  TIMEOUT_CYCLES = 64,
  parameter logic [3:0]   BOOT_ADDR      = 4'h0,
  parameter logic [31:0]  BOOT_CONFIG    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        boot_done,
  output logic        boot_ok,
  output logic        reg_write,
  output logic        reg_read,
  output logic [3:0]  reg_addr,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ready
);

  typedef enum logic [2:0] {
    ST_BOOT_WR     = 3'd0,
    ST_BOOT_WAIT   = 3'd1,
`ifdef UART_INIT_READBACK_EN
    ST_BOOT_RD     = 3'd2,
    ST_BOOT_RDWAIT = 3'd3,
`endif
    ST_IDLE        = 3'd4,
    ST_ISSUE       = 3'd5,
    ST_WAIT        = 3'd6,
    ST_RESP        = 3'd7
  } state_e;

  // Last counter value of a wait window. Reaching it without reg_ready aborts.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic        boot_done_q, boot_done_d;
  logic        boot_ok_q, boot_ok_d;
  logic        tmo_s;

  // States that wait on reg_ready and therefore run the timeout counter.
  function automatic logic is_wait_state(input state_e s);
    logic r;
    case (s)
      ST_BOOT_WAIT:   r = 1'b1;
`ifdef UART_INIT_READBACK_EN
      ST_BOOT_RDWAIT: r = 1'b1;
`endif
      ST_WAIT:        r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  assign tmo_s = (cnt_q == CNT_LAST);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_BOOT_WR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. When reg_ready and the timeout limit coincide, reg_ready wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT_WR: begin
        state_d = ST_BOOT_WAIT;
      end
      ST_BOOT_WAIT: begin
        if (reg_ready) begin
`ifdef UART_INIT_READBACK_EN
          state_d = ST_BOOT_RD;
`else
          state_d = ST_IDLE;
`endif
        end else if (tmo_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BOOT_WAIT;
        end
      end
`ifdef UART_INIT_READBACK_EN
      ST_BOOT_RD: begin
        state_d = ST_BOOT_RDWAIT;
      end
      ST_BOOT_RDWAIT: begin
        if (reg_ready || tmo_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BOOT_RDWAIT;
        end
      end
`endif
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (reg_ready || tmo_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_BOOT_WR;
      end
    endcase
  end

  // Timeout counter: cleared on entry to a wait state, then counts every cycle there.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) && is_wait_state(state_d)) begin
      cnt_d = 8'd0;
    end else if (is_wait_state(state_q)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath next values: command latch, response capture and boot status.
  always_comb begin
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    boot_done_d = boot_done_q;
    boot_ok_d   = boot_ok_q;
    case (state_q)
      ST_BOOT_WR: begin
        write_d = 1'b1;
        addr_d  = BOOT_ADDR;
        wdata_d = BOOT_CONFIG;
      end
      ST_BOOT_WAIT: begin
        if (reg_ready) begin
`ifdef UART_INIT_READBACK_EN
          write_d = 1'b0;
`else
          boot_done_d = 1'b1;
          boot_ok_d   = 1'b1;
`endif
        end else if (tmo_s) begin
          boot_done_d = 1'b1;
          boot_ok_d   = 1'b0;
        end else begin
          boot_done_d = boot_done_q;
        end
      end
`ifdef UART_INIT_READBACK_EN
      ST_BOOT_RDWAIT: begin
        if (reg_ready) begin
          boot_done_d = 1'b1;
          boot_ok_d   = (reg_rdata == BOOT_CONFIG);
        end else if (tmo_s) begin
          boot_done_d = 1'b1;
          boot_ok_d   = 1'b0;
        end else begin
          boot_done_d = boot_done_q;
        end
      end
`endif
      ST_IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
        end else begin
          write_d = write_q;
        end
      end
      ST_WAIT: begin
        if (reg_ready) begin
          rsp_rdata_d = write_q ? 32'h0000_0000 : reg_rdata;
          rsp_error_d = 1'b0;
        end else if (tmo_s) begin
          rsp_rdata_d = 32'h0000_0000;
          rsp_error_d = 1'b1;
        end else begin
          rsp_rdata_d = rsp_rdata_q;
        end
      end
      default: begin
        write_d = write_q;
      end
    endcase
  end

  // Datapath registers. Reset clears the command and the response together, so an aborted command never responds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= 8'd0;
      write_q     <= 1'b0;
      addr_q      <= 4'h0;
      wdata_q     <= 32'h0000_0000;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_error_q <= 1'b0;
      boot_done_q <= 1'b0;
      boot_ok_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      boot_done_q <= boot_done_d;
      boot_ok_q   <= boot_ok_d;
    end
  end

  // Output decode. The state sits at BOOT_WR while reset is low, so strobes are
  // gated by reset. This keeps the bus quiet during reset, and the boot write
  // lands in the first cycle after release.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    reg_write = 1'b0;
    reg_read  = 1'b0;
    reg_addr  = addr_q;
    reg_wdata = wdata_q;
    case (state_q)
      ST_BOOT_WR: begin
        reg_write = reset;
        if (reset) begin
          reg_addr  = BOOT_ADDR;
          reg_wdata = BOOT_CONFIG;
        end else begin
          reg_addr  = addr_q;
          reg_wdata = wdata_q;
        end
      end
`ifdef UART_INIT_READBACK_EN
      ST_BOOT_RD: begin
        reg_read = reset;
      end
`endif
      ST_ISSUE: begin
        reg_write = reset & write_q;
        reg_read  = reset & ~write_q;
      end
      default: begin
        reg_write = 1'b0;
      end
    endcase
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign boot_done = boot_done_q;
  assign boot_ok   = boot_ok_q;

endmodule

// File: tb/tb_uart_reg_initiator.sv
// Directed testbench for uart_reg_initiator (TIMEOUT_CYCLES=4, BOOT_CONFIG=32'h0000_A28B).
// A behavioural responder answers strobes after a programmable latency.
module tb_uart_reg_initiator;

  localparam int unsigned TMO    = 4;
  localparam logic [3:0]  B_ADDR = 4'h0;
  localparam logic [31:0] B_CFG  = 32'h0000_A28B;
`ifdef UART_INIT_READBACK_EN
  localparam int BOOT_TICKS = 4;
  localparam int BOOT_READS = 1;
`else
  localparam int BOOT_TICKS = 2;
  localparam int BOOT_READS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_addr = 4'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        boot_done;
  logic        boot_ok;
  logic        reg_write;
  logic        reg_read;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata = 32'h0;
  logic        reg_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Responder configuration (written by the stimulus) and state.
  int          rsp_lat = 1;
  bit          rd_fixed_mode = 1'b0;
  logic [31:0] rd_fixed = 32'h0;
  int          n_wr = 0;
  int          n_rd = 0;
  int          n_rule_bad = 0;
  int          pend = 0;
  logic [31:0] pend_data = 32'h0;
  bit          prev_strobe = 1'b0;
  logic [31:0] mem [16] = '{default: 32'h0};

  uart_reg_initiator #(
    .TIMEOUT_CYCLES (TMO),
    .BOOT_ADDR      (B_ADDR),
    .BOOT_CONFIG    (B_CFG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .boot_done (boot_done),
    .boot_ok   (boot_ok),
    .reg_write (reg_write),
    .reg_read  (reg_read),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ready (reg_ready)
  );

  always #5 clk = ~clk;

  // Responder: it sees a strobe mid-cycle and raises reg_ready rsp_lat cycles
  // later for one cycle. A latency of 0 means it never answers. It also counts
  // strobes that overlap or occur back to back.
  always @(negedge clk) begin
    reg_ready = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        reg_ready = 1'b1;
        reg_rdata = pend_data;
      end
    end
    if (reg_write && reg_read) n_rule_bad = n_rule_bad + 1;
    if ((reg_write || reg_read) && prev_strobe) n_rule_bad = n_rule_bad + 1;
    prev_strobe = reg_write || reg_read;
    if (reg_write) begin
      n_wr = n_wr + 1;
      mem[reg_addr] = reg_wdata;
    end
    if (reg_read) n_rd = n_rd + 1;
    if (reg_write || reg_read) begin
      pend_data = rd_fixed_mode ? rd_fixed : mem[reg_addr];
      pend = rsp_lat;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_boot(output int n, output bit saw_rsp);
    n = 0;
    saw_rsp = 1'b0;
    while (!boot_done && n < 20) begin
      tick();
      n = n + 1;
      if (rsp_valid) saw_rsp = 1'b1;
    end
  endtask

  task automatic run_cmd(input string tag, input logic w, input logic [3:0] a,
                         input logic [31:0] d, input int lat, input int exp_k,
                         input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int c;
    bit hold_bad;
    rsp_lat = lat;
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    c = 1;
    cmd_valid = 1'b0;
    check_eq({tag, "_strobe"}, 32'({reg_write, reg_read}), w ? 32'd2 : 32'd1);
    check_eq({tag, "_addr"}, 32'(reg_addr), 32'(a));
    check_eq({tag, "_wdata"}, reg_wdata, d);
    hold_bad = 1'b0;
    while (!rsp_valid && c < 40) begin
      tick();
      c = c + 1;
      if (!rsp_valid && (reg_addr != a || reg_wdata != d || cmd_ready || reg_write || reg_read))
        hold_bad = 1'b1;
    end
    check_eq({tag, "_latency"}, 32'(c), 32'(exp_k));
    check_eq({tag, "_hold"}, 32'(hold_bad), 32'd0);
    check_eq({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check_eq({tag, "_error"}, 32'(rsp_error), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check_eq({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
      check_eq({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_post_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int n;
    int w0;
    int r0;
    bit saw;

    // Reset state
    reset = 1'b0;
    rsp_lat = 1;
    repeat (3) tick();
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_boot_done", 32'(boot_done), 32'd0);
    check_eq("rst_boot_ok", 32'(boot_ok), 32'd0);
    check_eq("rst_strobes", 32'({reg_write, reg_read}), 32'd0);
    check_eq("rst_reg_addr", 32'(reg_addr), 32'd0);
    check_eq("rst_reg_wdata", reg_wdata, 32'd0);
    check_eq("rst_rsp", {rsp_rdata[30:0], rsp_error}, 32'd0);

    // Boot sequence: the strobe appears in the first cycle after release
    w0 = n_wr;
    r0 = n_rd;
    reset = 1'b1;
    #1;
    check_eq("boot_strobe", 32'(reg_write), 32'd1);
    check_eq("boot_addr", 32'(reg_addr), 32'(B_ADDR));
    check_eq("boot_wdata", reg_wdata, B_CFG);
    wait_boot(n, saw);
    check_eq("boot_ticks", 32'(n), 32'(BOOT_TICKS));
    check_eq("boot_ok", 32'(boot_ok), 32'd1);
    check_eq("boot_writes", 32'(n_wr - w0), 32'd1);
    check_eq("boot_reads", 32'(n_rd - r0), 32'(BOOT_READS));

    // Host commands
    run_cmd("wr0", 1'b1, 4'h0, 32'h1234_5678, 2, 4, 32'h0, 1'b0, 0);
    run_cmd("wr5", 1'b1, 4'h5, 32'hDEAD_BEEF, 1, 3, 32'h0, 1'b0, 0);
    run_cmd("rd5", 1'b0, 4'h5, 32'h0, 1, 3, 32'hDEAD_BEEF, 1'b0, 0);
    rd_fixed_mode = 1'b1;
    rd_fixed = 32'h0000_0055;
    run_cmd("rd2", 1'b0, 4'h2, 32'h0, 1, 3, 32'h0000_0055, 1'b0, 5);
    run_cmd("tmo", 1'b0, 4'h3, 32'h0, 0, 2 + TMO, 32'h0, 1'b1, 0);
    rd_fixed = 32'hCAFE_0004;
    run_cmd("edge", 1'b0, 4'h4, 32'h0, TMO, 2 + TMO, 32'hCAFE_0004, 1'b0, 0);
    rd_fixed_mode = 1'b0;

    // Reset in the middle of a read wait
    rsp_lat = 0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 4'h3;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    rsp_lat = 1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_reboot_strobe", 32'(reg_write), 32'd1);
    check_eq("mid_rst_reboot_addr", 32'(reg_addr), 32'(B_ADDR));
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_boot_done", 32'(boot_done), 32'd0);
    wait_boot(n, saw);
    check_eq("mid_rst_no_rsp", 32'(saw), 32'd0);
    check_eq("mid_rst_boot_ok", 32'(boot_ok), 32'd1);

    // Boot with a silent responder
    rsp_lat = 0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    wait_boot(n, saw);
    check_eq("boot_tmo_ticks", 32'(n), 32'(1 + TMO));
    check_eq("boot_tmo_ok", 32'(boot_ok), 32'd0);
    check_eq("boot_tmo_cmd_ready", 32'(cmd_ready), 32'd1);

`ifdef UART_INIT_READBACK_EN
    // Boot readback mismatch
    rsp_lat = 1;
    rd_fixed_mode = 1'b1;
    rd_fixed = 32'h0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    wait_boot(n, saw);
    check_eq("boot_mm_done", 32'(boot_done), 32'd1);
    check_eq("boot_mm_ok", 32'(boot_ok), 32'd0);
    tick();
    check_eq("boot_mm_cmd_ready", 32'(cmd_ready), 32'd1);
`endif

    check_eq("strobe_rules", 32'(n_rule_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
